// File: rtl/ex_pkg.sv
// Shared widths and packet types for the execute operand stage.
// alu_pkt_t is sized from these defaults, so the top's width parameters must match them.
package ex_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 5;
    localparam int unsigned OPC_W  = 4;

    typedef logic [OPC_W-1:0] alu_opc_t;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        alu_opc_t          opc;
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] dest;
    } alu_pkt_t;

endpackage

// File: rtl/ex_bypass_mux.sv
// Operand source select for one register read:
// hardwired zero, lowest-index matching writeback port, or regfile data.
module ex_bypass_mux #(
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned XLEN      = 32,
    parameter bit          ZERO_PREG = 1'b1
) (
    input  logic [PREG_W-1:0]          rs_i,
    input  logic [XLEN-1:0]            rf_data_i,
    input  logic [WB_PORTS-1:0]        wb_valid_i,
    input  logic [WB_PORTS*PREG_W-1:0] wb_dest_i,
    input  logic [WB_PORTS*XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]            data_o
);

    always_comb begin
        data_o = rf_data_i;
        // Walk from the highest port down so the lowest matching port is applied last.
        for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (wb_valid_i[k] && (wb_dest_i[k*PREG_W +: PREG_W] == rs_i)) begin
                data_o = wb_data_i[k*XLEN +: XLEN];
            end
        end
        if (ZERO_PREG && (rs_i == '0)) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Issue-to-ALU operand stage: reads/bypasses operands and registers an ALU packet,
// with a one-entry skid behind the output register so ready_o is purely registered.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int unsigned XLEN      = ex_pkg::XLEN,
    parameter int unsigned PREG_W    = ex_pkg::PREG_W,
    parameter int unsigned ROB_W     = ex_pkg::ROB_W,
    parameter int unsigned OPC_W     = ex_pkg::OPC_W,
    parameter int unsigned WB_PORTS  = 2,
    parameter bit          ZERO_PREG = 1'b1
) (
    input  logic                       cpu_clock_i,
    input  logic                       cpu_reset_ni,
    input  logic                       flush_i,
    input  logic [ROB_W+2*PREG_W:0]    data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [ROB_W-1:0]           rob_o,
    output logic [PREG_W-1:0]          rs1_o,
    output logic [PREG_W-1:0]          rs2_o,
    input  logic [XLEN-1:0]            rs1_data_i,
    input  logic [XLEN-1:0]            rs2_data_i,
    input  logic [OPC_W-1:0]           opcode_i,
    input  logic                       imm_i,
    input  logic [XLEN-1:0]            immediate_i,
    input  logic [PREG_W-1:0]          dest_i,
    input  logic [WB_PORTS-1:0]        wb_valid_i,
    input  logic [WB_PORTS*PREG_W-1:0] wb_dest_i,
    input  logic [WB_PORTS*XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]            alu_a,
    output logic [XLEN-1:0]            alu_b,
    output logic [OPC_W-1:0]           alu_opc,
    output logic [ROB_W-1:0]           alu_rob_id,
    output logic [PREG_W-1:0]          alu_dest,
    output logic                       alu_valid,
    input  logic                       alu_ready_i
);

    alu_pkt_t          out_q, out_d, skid_q, skid_d, new_pkt;
    logic              alu_valid_q, alu_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic              accept, consume;
    logic              unused_spare;

    assign rob_o        = data_i[ROB_W-1:0];
    assign unused_spare = data_i[ROB_W];
    assign rs1_o        = data_i[ROB_W+1 +: PREG_W];
    assign rs2_o        = data_i[ROB_W+1+PREG_W +: PREG_W];

    ex_bypass_mux #(
        .WB_PORTS  (WB_PORTS),
        .PREG_W    (PREG_W),
        .XLEN      (XLEN),
        .ZERO_PREG (ZERO_PREG)
    ) u_bypass_rs1 (
        .rs_i       (rs1_o),
        .rf_data_i  (rs1_data_i),
        .wb_valid_i (wb_valid_i),
        .wb_dest_i  (wb_dest_i),
        .wb_data_i  (wb_data_i),
        .data_o     (rs1_val)
    );

    ex_bypass_mux #(
        .WB_PORTS  (WB_PORTS),
        .PREG_W    (PREG_W),
        .XLEN      (XLEN),
        .ZERO_PREG (ZERO_PREG)
    ) u_bypass_rs2 (
        .rs_i       (rs2_o),
        .rf_data_i  (rs2_data_i),
        .wb_valid_i (wb_valid_i),
        .wb_dest_i  (wb_dest_i),
        .wb_data_i  (wb_data_i),
        .data_o     (rs2_val)
    );

    assign ready_o = !skid_valid_q;
    assign accept  = valid_i && ready_o && !flush_i;
    assign consume = alu_valid_q && alu_ready_i;

    always_comb begin
        new_pkt.a    = rs1_val;
        new_pkt.b    = imm_i ? immediate_i : rs2_val;
        new_pkt.opc  = opcode_i;
        new_pkt.rob  = rob_o;
        new_pkt.dest = dest_i;
    end

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        alu_valid_d  = alu_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            alu_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // ready_o is low here, so no new uop can compete with the drain.
            if (consume) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!alu_valid_q || alu_ready_i) begin
                out_d       = new_pkt;
                alu_valid_d = 1'b1;
            end else begin
                skid_d       = new_pkt;
                skid_valid_d = 1'b1;
            end
        end else if (consume) begin
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            alu_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            alu_valid_q  <= alu_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign alu_a      = out_q.a;
    assign alu_b      = out_q.b;
    assign alu_opc    = out_q.opc;
    assign alu_rob_id = out_q.rob;
    assign alu_dest   = out_q.dest;
    assign alu_valid  = alu_valid_q;

endmodule
